// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised synchronous RAM.
package ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int unsigned READ_FIRST  = 0;
  localparam int unsigned WRITE_FIRST = 1;

  // Ceiling log2 with a fixed loop bound so it elaborates as a constant.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_sync_param_if.sv
// Request/response bundle between a RAM client and ram_sync_param.
interface ram_sync_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  en;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  busy;
  logic                  addr_err;

  modport master (
    output en, wr, address, data_in,
    input  data_out, data_valid, busy, addr_err
  );

  modport slave (
    input  en, wr, address, data_in,
    output data_out, data_valid, busy, addr_err
  );
endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every word once, holding busy until done.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned IDX_W          = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             busy,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + IDX_W'(1);
      if (ptr_q == LAST_IDX) begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    end
  end

  // A reset mid-clear restarts the walk from word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/ram_sync_param.sv
// Single-port synchronous RAM with registered read, valid/error pulses and post-reset clear.
module ram_sync_param
  import ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           ADDR_WIDTH     = 8,
  parameter int unsigned           DEPTH          = 256,
  parameter int unsigned           READ_MODE      = READ_FIRST,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_sync_param_if.slave  bus
);

  localparam int unsigned         IDX_W     = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  busy;
  logic                  clr_we;
  logic [IDX_W-1:0]      clr_addr;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] data_out_q,   data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  addr_err_q,   addr_err_d;

  logic                  acc_c;
  logic                  in_range_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  mem_we_c;
  logic [IDX_W-1:0]      mem_waddr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;

  ram_clear_seq #(
    .DEPTH          (DEPTH),
    .IDX_W          (IDX_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Requests are only seen once the clear walk has finished.
  always_comb begin
    acc_c      = bus.en && !busy;
    in_range_c = ({1'b0, bus.address} < DEPTH_LIM);
    idx_c      = IDX_W'(bus.address);
  end

  // Write port: the clear sequencer owns it while busy, user writes otherwise.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = idx_c;
    mem_wdata_c = bus.data_in;
    if (clr_we) begin
      mem_we_c    = rst_n;
      mem_waddr_c = clr_addr;
      mem_wdata_c = CLEAR_VALUE;
    end else if (acc_c && bus.wr && in_range_c) begin
      mem_we_c    = rst_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    if (acc_c) begin
      if (!in_range_c) begin
        addr_err_d = 1'b1;
        if (!bus.wr) begin
          data_out_d   = '0;
          data_valid_d = 1'b1;
        end
      end else if (bus.wr) begin
        if (READ_MODE == WRITE_FIRST) begin
          data_out_d   = bus.data_in;
          data_valid_d = 1'b1;
        end
      end else begin
        data_out_d   = mem_q[idx_c];
        data_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_ram_sync_param.sv
// Directed bench for ram_sync_param: read-first (a) and write-first (b) instances driven in lockstep.
module tb_ram_sync_param;
  import ram_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  ram_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_a ();
  ram_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_b ();

  ram_sync_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .READ_MODE(READ_FIRST),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5)
  ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));

  ram_sync_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .READ_MODE(WRITE_FIRST),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5)
  ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic w, input logic [3:0] a, input logic [7:0] d);
    if_a.en = e; if_a.wr = w; if_a.address = a; if_a.data_in = d;
    if_b.en = e; if_b.wr = w; if_b.address = a; if_b.data_in = d;
  endtask

  // One request, then the registered response one edge later for both instances.
  task automatic op(input string tag, input logic e, input logic w, input logic [3:0] a,
                    input logic [7:0] d, input logic [7:0] eoa, input logic eva,
                    input logic [7:0] eob, input logic evb, input logic eerr);
    drive(e, w, a, d);
    @(negedge clk);
    check({tag, " a.data_out"},   32'(if_a.data_out),   32'(eoa));
    check({tag, " a.data_valid"}, 32'(if_a.data_valid), 32'(eva));
    check({tag, " b.data_out"},   32'(if_b.data_out),   32'(eob));
    check({tag, " b.data_valid"}, 32'(if_b.data_valid), 32'(evb));
    check({tag, " a.addr_err"},   32'(if_a.addr_err),   32'(eerr));
    check({tag, " b.addr_err"},   32'(if_b.addr_err),   32'(eerr));
  endtask

  // Reset, release, then count busy cycles while offering requests that must be dropped.
  // abort_at > 0 pulses reset once after that many busy cycles and restarts the count.
  task automatic reset_and_count(input int abort_at, output int na, output int nb);
    bit aborted;
    aborted = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst a.data_out",   32'(if_a.data_out),   32'h0);
    check("rst b.data_valid", 32'(if_b.data_valid), 32'h0);
    check("rst a.addr_err",   32'(if_a.addr_err),   32'h0);
    check("rst b.busy",       32'(if_b.busy),       32'h1);
    rst_n = 1'b1;
    na = 0;
    nb = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      check("busy a.valid", 32'(if_a.data_valid), 32'h0);
      check("busy b.valid", 32'(if_b.data_valid), 32'h0);
      check("busy b.err",   32'(if_b.addr_err),   32'h0);
      if (!if_a.busy && !if_b.busy) break;
      if (if_a.busy) na++;
      if (if_b.busy) nb++;
      if (abort_at > 0 && !aborted && na == abort_at) begin
        aborted = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 8'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        na = 0;
        nb = 0;
        continue;
      end
      drive(1'b1, cyc[0], cyc[1] ? 4'd13 : 4'd3, 8'hEE);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  logic [7:0] exp_rd [12];

  initial begin
    int na;
    int nb;
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'd0);

    reset_and_count(0, na, nb);
    check("clear len a", 32'(na), 32'd12);
    check("clear len b", 32'(nb), 32'd12);

    for (int k = 0; k < 12; k++)
      op("clr read", 1'b1, 1'b0, 4'(k), 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0);

    for (int k = 0; k < 4; k++)
      op("write k", 1'b1, 1'b1, 4'(k), 8'(k + 2), 8'hA5, 1'b0, 8'(k + 2), 1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      op("read k", 1'b1, 1'b0, 4'(k), 8'h00, 8'(k + 2), 1'b1, 8'(k + 2), 1'b1, 1'b0);

    op("write 5",  1'b1, 1'b1, 4'd5, 8'h3C, 8'h05, 1'b0, 8'h3C, 1'b1, 1'b0);
    op("read 5",   1'b1, 1'b0, 4'd5, 8'h00, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0);
    op("wr oor",   1'b1, 1'b1, 4'd13, 8'h77, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b1);
    op("rd oor",   1'b1, 1'b0, 4'd13, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);
    op("idle",     1'b0, 1'b0, 4'd1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    op("rd 15",    1'b1, 1'b0, 4'd15, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);

    exp_rd = '{8'h02, 8'h03, 8'h04, 8'h05, 8'hA5, 8'h3C,
               8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    for (int k = 0; k < 12; k++)
      op("rd back", 1'b1, 1'b0, 4'(k), 8'h00, exp_rd[k], 1'b1, exp_rd[k], 1'b1, 1'b0);
    op("hold",     1'b0, 1'b1, 4'd2, 8'h99, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0);

    op("wr 2",     1'b1, 1'b1, 4'd2, 8'h11, 8'hA5, 1'b0, 8'h11, 1'b1, 1'b0);
    reset_and_count(6, na, nb);
    check("reclear len a", 32'(na), 32'd12);
    check("reclear len b", 32'(nb), 32'd12);
    for (int k = 0; k < 12; k++)
      op("reclr read", 1'b1, 1'b0, 4'(k), 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0);
    op("end idle", 1'b0, 1'b0, 4'd0, 8'h00, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
